// File: rtl/fetch_decode_buffer.sv
// Purpose : in-order instruction queue plus IF/ID output register between program_memory and decode.
// Latency : 1 cycle fetch->ins_id on bypass (empty queue, no stall); queued words one cycle after stall drops.
// Backpr. : stall_pm asserted at count >= DEPTH-1 (one skid slot); a fetch into a full queue under stall is dropped and sets overflow.
//
// Ports:
//   clk, reset        single clock, async active-high reset
//   ins, current_address, fetch_valid   fetched word, its PC, and its valid strobe
//   flush             taken jump/branch: discard everything queued and in flight
//   stall             decode cannot accept this cycle
//   stall_pm          hold PC in program_memory
//   ins_id, pc_id, valid_id   registered instruction presented to decode
//   fifo_count        queue occupancy
//   overflow          sticky: a fetch was lost (cleared only by reset)
module fetch_decode_buffer #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                ins,
  input  logic [15:0]                current_address,
  input  logic                       fetch_valid,
  input  logic                       flush,
  input  logic                       stall,
  output logic                       stall_pm,
  output logic [31:0]                ins_id,
  output logic [15:0]                pc_id,
  output logic                       valid_id,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] SKID_CNT  = CNT_W'(DEPTH - 1);

  typedef struct packed {
    logic [31:0] ins;
    logic [15:0] pc;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [31:0]        ins_id_q, ins_id_d;
  logic [15:0]        pc_id_q,  pc_id_d;
  logic               valid_id_q, valid_id_d;
  logic               overflow_q, overflow_d;

  logic               push, pop;
  logic               fifo_empty, fifo_full;
  entry_t             head;
  entry_t             in_entry;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign head       = mem_q[rd_ptr_q];
  assign in_entry   = '{ins: ins, pc: current_address};

  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    ins_id_d   = ins_id_q;
    pc_id_d    = pc_id_q;
    valid_id_d = valid_id_q;
    overflow_d = overflow_q;

    if (flush) begin
      // Wrong-path cleanup; the pointer/count reset is handled below.
      ins_id_d   = NOP;
      pc_id_d    = '0;
      valid_id_d = 1'b0;
    end else if (stall) begin
      if (fetch_valid) begin
        if (fifo_full) overflow_d = 1'b1;
        else           push       = 1'b1;
      end
    end else begin
      if (!fifo_empty) begin
        // Older queued words always go first; a same-cycle fetch joins the tail.
        pop        = 1'b1;
        push       = fetch_valid;
        ins_id_d   = head.ins;
        pc_id_d    = head.pc;
        valid_id_d = 1'b1;
      end else if (fetch_valid) begin
        ins_id_d   = ins;
        pc_id_d    = current_address;
        valid_id_d = 1'b1;
      end else begin
        ins_id_d   = NOP;
        valid_id_d = 1'b0;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ins_id_q   <= NOP;
      pc_id_q    <= '0;
      valid_id_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ins_id_q   <= ins_id_d;
      pc_id_q    <= pc_id_d;
      valid_id_q <= valid_id_d;
      overflow_q <= overflow_d;
    end
  end

  // Threshold at DEPTH-1 leaves room for the word already leaving program_memory.
  assign stall_pm   = (count_q >= SKID_CNT);
  assign ins_id     = ins_id_q;
  assign pc_id      = pc_id_q;
  assign valid_id   = valid_id_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
module tb_fetch_decode_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ins = '0;
  logic [15:0] current_address = '0;
  logic        fetch_valid = 1'b0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        stall_pm;
  logic [31:0] ins_id;
  logic [15:0] pc_id;
  logic        valid_id;
  logic [2:0]  fifo_count;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  fetch_decode_buffer #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .ins             (ins),
    .current_address (current_address),
    .fetch_valid     (fetch_valid),
    .flush           (flush),
    .stall           (stall),
    .stall_pm        (stall_pm),
    .ins_id          (ins_id),
    .pc_id           (pc_id),
    .valid_id        (valid_id),
    .fifo_count      (fifo_count),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic cyc(input logic fv, input logic [31:0] i, input logic [15:0] p,
                     input logic st, input logic fl);
    fetch_valid = fv; ins = i; current_address = p; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [31:0] i,
                         input logic [15:0] p, input int cnt, input logic ovf);
    chk({tag, ".valid"},    {31'b0, valid_id},   {31'b0, v});
    chk({tag, ".ins"},      ins_id,              i);
    chk({tag, ".pc"},       {16'b0, pc_id},      {16'b0, p});
    chk({tag, ".count"},    {29'b0, fifo_count}, cnt);
    chk({tag, ".stall_pm"}, {31'b0, stall_pm},   (cnt >= DEPTH - 1) ? 1 : 0);
    chk({tag, ".overflow"}, {31'b0, overflow},   {31'b0, ovf});
  endtask

  initial begin
    // Reset held from time 0; outputs at reset values before any clock edge.
    #2;
    exp_out("por", 1'b0, NOP, 16'h0, 0, 1'b0);
    reset = 1'b0;

    // Streaming bypass: each word one cycle after its fetch, queue stays empty.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h1111_0000 + k, 16'(k), 1'b0, 1'b0);
      exp_out($sformatf("stream%0d", k), 1'b1, 32'h1111_0000 + k, 16'(k), 0, 1'b0);
    end
    cyc(1'b0, 32'hDEAD_BEEF, 16'hFFFF, 1'b0, 1'b0);
    exp_out("stream_idle", 1'b0, NOP, 16'h0003, 0, 1'b0);

    // Stall and back-pressure.
    cyc(1'b1, 32'h2222_0000, 16'h0010, 1'b0, 1'b0);
    exp_out("st_a", 1'b1, 32'h2222_0000, 16'h0010, 0, 1'b0);
    cyc(1'b1, 32'h2222_0001, 16'h0011, 1'b1, 1'b0);
    exp_out("st_b", 1'b1, 32'h2222_0000, 16'h0010, 1, 1'b0);
    cyc(1'b1, 32'h2222_0002, 16'h0012, 1'b1, 1'b0);
    exp_out("st_c", 1'b1, 32'h2222_0000, 16'h0010, 2, 1'b0);
    cyc(1'b1, 32'h2222_0003, 16'h0013, 1'b1, 1'b0);
    exp_out("st_d", 1'b1, 32'h2222_0000, 16'h0010, 3, 1'b0);
    cyc(1'b1, 32'h2222_0004, 16'h0014, 1'b0, 1'b0);
    exp_out("st_e", 1'b1, 32'h2222_0001, 16'h0011, 3, 1'b0);
    cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    exp_out("st_f", 1'b1, 32'h2222_0002, 16'h0012, 2, 1'b0);
    cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    exp_out("st_g", 1'b1, 32'h2222_0003, 16'h0013, 1, 1'b0);
    cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    exp_out("st_h", 1'b1, 32'h2222_0004, 16'h0014, 0, 1'b0);
    cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    exp_out("st_i", 1'b0, NOP, 16'h0014, 0, 1'b0);

    // Flush with stall and a same-cycle fetch: flush wins, PC 9 is lost.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'h3333_0006 + k, 16'(6 + k), 1'b1, 1'b0);
    end
    exp_out("fl_fill", 1'b0, NOP, 16'h0014, 3, 1'b0);
    cyc(1'b1, 32'h3333_0009, 16'h0009, 1'b1, 1'b1);
    exp_out("fl_flush", 1'b0, NOP, 16'h0000, 0, 1'b0);
    cyc(1'b1, 32'h3333_0005, 16'h0005, 1'b0, 1'b0);
    exp_out("fl_target", 1'b1, 32'h3333_0005, 16'h0005, 0, 1'b0);
    cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    exp_out("fl_idle", 1'b0, NOP, 16'h0005, 0, 1'b0);

    // Full push+pop: no drop, count stays at DEPTH, new word exits 4 cycles later.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h5555_0000 + k, 16'(16'h40 + k), 1'b1, 1'b0);
    end
    exp_out("pp_full", 1'b0, NOP, 16'h0005, 4, 1'b0);
    cyc(1'b1, 32'h5555_0004, 16'h0044, 1'b0, 1'b0);
    exp_out("pp_swap", 1'b1, 32'h5555_0000, 16'h0040, 4, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
      exp_out($sformatf("pp_drain%0d", k), 1'b1, 32'h5555_0000 + k, 16'(16'h40 + k), 4 - k, 1'b0);
    end
    cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    exp_out("pp_idle", 1'b0, NOP, 16'h0044, 0, 1'b0);

    // Overflow: fifth word under stall is dropped and overflow sticks.
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 32'h4444_0000 + k, 16'(16'h20 + k), 1'b1, 1'b0);
      exp_out($sformatf("ov_fill%0d", k), 1'b0, NOP, 16'h0044, k + 1, 1'b0);
    end
    cyc(1'b1, 32'h4444_0004, 16'h0024, 1'b1, 1'b0);
    exp_out("ov_drop", 1'b0, NOP, 16'h0044, 4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
      exp_out($sformatf("ov_drain%0d", k), 1'b1, 32'h4444_0000 + k, 16'(16'h20 + k), 3 - k, 1'b1);
    end
    cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    exp_out("ov_idle", 1'b0, NOP, 16'h0023, 0, 1'b1);
    cyc(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    exp_out("ov_flush", 1'b0, NOP, 16'h0000, 0, 1'b1);

    // Mid-operation reset with count = 2 and valid_id = 1.
    cyc(1'b1, 32'h6666_0000, 16'h0060, 1'b0, 1'b0);
    cyc(1'b1, 32'h6666_0001, 16'h0061, 1'b1, 1'b0);
    cyc(1'b1, 32'h6666_0002, 16'h0062, 1'b1, 1'b0);
    exp_out("rst_pre", 1'b1, 32'h6666_0000, 16'h0060, 2, 1'b1);
    fetch_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    exp_out("rst_async", 1'b0, NOP, 16'h0000, 0, 1'b0);
    #1;
    reset = 1'b0;
    cyc(1'b1, 32'h7777_0000, 16'h0070, 1'b0, 1'b0);
    exp_out("rst_after", 1'b1, 32'h7777_0000, 16'h0070, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_decode_buffer.md
# fetch_decode_buffer

Instruction queue and IF/ID pipeline register between `program_memory` and the decode stage.
- Captures each fetched `ins`/`current_address` pair into a small in-order FIFO and presents the oldest entry to decode through a registered output stage.
- Absorbs decode-side stalls and generates `stall_pm` back-pressure so the PC holds instead of losing words.
- Flushes all wrong-path instructions when a jump or branch is taken.

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `NOP`, 32'h0000_0000: instruction word driven on `ins_id` when no valid entry is present.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ins`  in  32  instruction word from `program_memory`.
- `current_address`  in  16  PC of `ins`.
- `fetch_valid`  in  1  `ins`/`current_address` hold a real fetch this cycle.
- `flush`  in  1  taken jump/branch (driven together with `pc_mux_sel`); discard every queued and in-flight word.
- `stall`  in  1  decode cannot accept a new instruction this cycle.
- `stall_pm`  out  1  hold the PC in `program_memory`.
- `ins_id`  out  32  registered instruction presented to decode.
- `pc_id`  out  16  registered PC of `ins_id`.
- `valid_id`  out  1  `ins_id`/`pc_id` are valid.
- `fifo_count`  out  clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky error flag: a fetch was dropped.

## Operation

Reset values:
- `ins_id` = `NOP`, `pc_id` = 0, `valid_id` = 0, `fifo_count` = 0, `overflow` = 0.
- `stall_pm` = 0; it is derived from count.
- Read and write pointers = 0.

Per-cycle priority, highest first:
- **flush:**
  - Pointers and count go to 0.
  - `valid_id` goes to 0, `ins_id` to `NOP`, `pc_id` to 0.
  - A `fetch_valid` word in the same cycle is discarded.
  - `stall` is ignored.
- **stall = 1:**
  - Output registers hold.
  - A `fetch_valid` word is pushed if count < DEPTH.
- **stall = 0:**
  - The output registers load the next instruction:
    - If FIFO is non-empty, the FIFO head is popped into them.
    - Else, if `fetch_valid`, the input word bypasses the FIFO into them.
    - Else, `valid_id` goes to 0, `ins_id` to `NOP`, and `pc_id` holds.
  - If the FIFO was non-empty, a `fetch_valid` word in the same cycle is pushed. This push is allowed even at count = DEPTH, because the pop frees a slot.

Other rules:
- Order is strictly preserved; an instruction never overtakes an older one.
- `stall_pm` = (`fifo_count` ≥ DEPTH−1), combinational.
  - This leaves one slot of skid for the word already in flight from `program_memory`.
- **Drop:** `fetch_valid` with count = DEPTH, `stall` = 1 and no flush.
  - The word is lost and `overflow` is set.
  - `overflow` clears only on `reset`; `flush` does not clear it.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- Count is updated as +1 on push only, −1 on pop only, unchanged on push+pop.

## Timing

- **Bypass latency:** `fetch_valid` at edge N with an empty FIFO and `stall` = 0 gives `valid_id` = 1 after edge N+1. Count stays 0.
- **Queued latency:** one cycle after `stall` deasserts, the oldest queued word appears on `ins_id`.
- **flush:** sampled at edge N. After N+1: `valid_id` = 0, count = 0, `stall_pm` = 0. The first fetch arriving after N+1 (jump target) follows normal bypass timing.
- **Reset asserted mid-operation:** all outputs reach reset values without waiting for a clock edge.
- **Reset deassertion:** the first push can occur on the next rising edge.
- **flush and stall together:** flush wins.
- **Full, push and !stall together:** no drop, and count stays at DEPTH.

## Test plan

- **Reset:** raise `reset` for 2 ns between clock edges while count = 2 and `valid_id` = 1 → immediately `ins_id` = 0, `pc_id` = 0, `valid_id` = 0, `fifo_count` = 0, `overflow` = 0, `stall_pm` = 0.
- **Streaming:** `fetch_valid` = 1 for 4 cycles with words 32'h1111_0000..32'h1111_0003 at PC 0..3, `stall` = 0 → each appears on `ins_id`/`pc_id` one cycle later in order; `fifo_count` stays 0 and `stall_pm` stays 0.
- **Stall and back-pressure (DEPTH = 4):** stream continuously with `stall` = 1 for 3 cycles.
  - `fifo_count` goes 1, 2, 3; `stall_pm` = 1 once count = 3.
  - After `stall` drops, the held word, then the queued words, emerge in PC order with no gaps or duplicates.
- **Flush:** with count = 3 and `stall` = 1, assert `flush` with `fetch_valid` = 1 (PC 0x0009), then fetch PC 0x0005.
  - Next cycle: count = 0, `valid_id` = 0, `ins_id` = 0.
  - PC 0x0009 never appears; PC 0x0005 appears one cycle after its fetch.
- **Overflow:** hold `stall` = 1 and keep `fetch_valid` = 1 while ignoring `stall_pm`.
  - The 5th word (count = 4) is dropped and `overflow` = 1.
  - After release, only the first 4 words drain.
  - `overflow` stays 1 through a flush and clears only on reset.
- **Full push+pop:** count = 4, `stall` = 0, `fetch_valid` = 1 → head popped, new word queued, count stays 4, `overflow` stays 0; the new word exits 4 cycles later.
